// File: rtl/nn_forward.sv
// nn_forward: forward-propagation engine of the 2-3-2 backprop network core.
// Holds the 17 layer-2/layer-3 coefficients, fetches samples (k1,k2,t1,t2)
// from a 4-entry ROM and computes hidden (a2) and output (a3) activations
// through a piecewise-linear sigmoid. All data is signed Q6.10 (1.0 = 1024).
//
// Ports:
//   clk, reset (sync, active-low)
//   din             start a forward pass (sampled only in IDLE)
//   select_initial  load every coefficient from its cap_delta_* input
//   update_coeff    add cap_delta_* to every coefficient (saturating)
//   input_k_1/2     external sample inputs (FORWARD_EXT_INPUT_EN only)
//   cap_delta_*     coefficient init values / deltas
//   w3_*            current layer-3 weights
//   a2_*, a3_*      hidden / output activations
//   k1,k2,t1,t2     current sample inputs and targets
//   finish_updating one-cycle pulse after each update
//
// Build option: define FORWARD_EXT_INPUT_EN to latch k1/k2 from input_k_1/2
// instead of the ROM (targets still come from the ROM).
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for din
//   FETCH | latch k,t from ROM, advance ROM address
//   L2    | register hidden activations a2
//   L3    | register output activations a3

module nn_forward (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    input  logic        select_initial,
    input  logic        update_coeff,
    input  logic [15:0] input_k_1,
    input  logic [15:0] input_k_2,
    input  logic [15:0] cap_delta_b2_1,
    input  logic [15:0] cap_delta_b2_2,
    input  logic [15:0] cap_delta_b2_3,
    input  logic [15:0] cap_delta_w2_11,
    input  logic [15:0] cap_delta_w2_12,
    input  logic [15:0] cap_delta_w2_13,
    input  logic [15:0] cap_delta_w2_21,
    input  logic [15:0] cap_delta_w2_22,
    input  logic [15:0] cap_delta_w2_23,
    input  logic [15:0] cap_delta_b3_1,
    input  logic [15:0] cap_delta_b3_2,
    input  logic [15:0] cap_delta_w3_11,
    input  logic [15:0] cap_delta_w3_12,
    input  logic [15:0] cap_delta_w3_21,
    input  logic [15:0] cap_delta_w3_22,
    input  logic [15:0] cap_delta_w3_31,
    input  logic [15:0] cap_delta_w3_32,
    output logic [15:0] w3_11,
    output logic [15:0] w3_12,
    output logic [15:0] w3_21,
    output logic [15:0] w3_22,
    output logic [15:0] w3_31,
    output logic [15:0] w3_32,
    output logic [15:0] a2_1,
    output logic [15:0] a2_2,
    output logic [15:0] a2_3,
    output logic [15:0] a3_1,
    output logic [15:0] a3_2,
    output logic [15:0] k1,
    output logic [15:0] k2,
    output logic [15:0] t1,
    output logic [15:0] t2,
    output logic        finish_updating
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] L2    = 2'd2;
    localparam logic [1:0] L3    = 2'd3;

    // Saturate a wide signed value to 16 bits.
    function automatic logic signed [15:0] sat16(input logic signed [24:0] x);
        if (x > 25'sd32767)
            return 16'sh7fff;
        else if (x < -25'sd32768)
            return 16'sh8000;
        else
            return x[15:0];
    endfunction

    // Q6.10 multiply: full 32-bit product, arithmetic shift back to Q6.10.
    function automatic logic signed [24:0] mul_q(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        return 25'(p >>> 10);
    endfunction

    // Piecewise-linear sigmoid on |z|, mirrored as 1.0 - y for negative z.
    function automatic logic signed [15:0] sigmoid(input logic signed [15:0] z);
        logic [16:0] x;
        logic [15:0] y;
        // 17-bit magnitude so that -32768 maps to +32768 cleanly
        x = z[15] ? (~{z[15], z} + 17'd1) : {1'b0, z};
        if (x >= 17'd5120)
            y = 16'd1024;
        else if (x >= 17'd2432)
            y = 16'(x >> 5) + 16'd864;
        else if (x >= 17'd1024)
            y = 16'(x >> 3) + 16'd640;
        else
            y = 16'(x >> 2) + 16'd512;
        return z[15] ? $signed(16'd1024 - y) : $signed(y);
    endfunction

    // Coefficient index map:
    //   0..2  b2_1..3      3..5  w2_11,12,13    6..8  w2_21,22,23
    //   9..10 b3_1..2      11..16 w3_11,12,21,22,31,32
    logic signed [15:0] delta [17];
    logic signed [15:0] coef  [17];

    assign delta[0]  = cap_delta_b2_1;
    assign delta[1]  = cap_delta_b2_2;
    assign delta[2]  = cap_delta_b2_3;
    assign delta[3]  = cap_delta_w2_11;
    assign delta[4]  = cap_delta_w2_12;
    assign delta[5]  = cap_delta_w2_13;
    assign delta[6]  = cap_delta_w2_21;
    assign delta[7]  = cap_delta_w2_22;
    assign delta[8]  = cap_delta_w2_23;
    assign delta[9]  = cap_delta_b3_1;
    assign delta[10] = cap_delta_b3_2;
    assign delta[11] = cap_delta_w3_11;
    assign delta[12] = cap_delta_w3_12;
    assign delta[13] = cap_delta_w3_21;
    assign delta[14] = cap_delta_w3_22;
    assign delta[15] = cap_delta_w3_31;
    assign delta[16] = cap_delta_w3_32;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 17; i++) coef[i] <= '0;
            finish_updating <= 1'b0;
        end else begin
            if (select_initial) begin
                for (int i = 0; i < 17; i++) coef[i] <= delta[i];
            end else if (update_coeff) begin
                for (int i = 0; i < 17; i++)
                    coef[i] <= sat16(25'(coef[i]) + 25'(delta[i]));
            end
            finish_updating <= update_coeff & ~select_initial;
        end
    end

    assign w3_11 = coef[11];
    assign w3_12 = coef[12];
    assign w3_21 = coef[13];
    assign w3_22 = coef[14];
    assign w3_31 = coef[15];
    assign w3_32 = coef[16];

    // Sample ROM
    logic [1:0]  rom_addr;
    logic [15:0] rom_k1, rom_k2, rom_t1, rom_t2;

    always_comb begin
        rom_k1 = 16'd0;
        rom_k2 = 16'd0;
        rom_t1 = 16'd0;
        rom_t2 = 16'd1024;
        case (rom_addr)
            2'd0: begin rom_k1 = 16'd8192; rom_k2 = 16'd8192; rom_t1 = 16'd1024; rom_t2 = 16'd0;    end
            2'd1: begin rom_k1 = 16'd1024; rom_k2 = 16'd2048; rom_t1 = 16'd0;    rom_t2 = 16'd1024; end
            2'd2: begin rom_k1 = 16'd2048; rom_k2 = 16'd1024; rom_t1 = 16'd1024; rom_t2 = 16'd0;    end
            default: begin rom_k1 = 16'd0; rom_k2 = 16'd0;    rom_t1 = 16'd0;    rom_t2 = 16'd1024; end
        endcase
    end

    logic [15:0] fetch_k1, fetch_k2;
`ifdef FORWARD_EXT_INPUT_EN
    assign fetch_k1 = input_k_1;
    assign fetch_k2 = input_k_2;
    logic unused_rom_k;
    assign unused_rom_k = ^{rom_k1, rom_k2};
`else
    assign fetch_k1 = rom_k1;
    assign fetch_k2 = rom_k2;
    logic unused_ext_k;
    assign unused_ext_k = ^{input_k_1, input_k_2};
`endif

    // Datapath
    logic signed [15:0] a2_r [3];
    logic signed [15:0] a3_r [2];
    logic signed [15:0] a2_next [3];
    logic signed [15:0] a3_next [2];

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            a2_next[j] = sigmoid(sat16(25'(coef[j])
                                       + mul_q(coef[3 + j], $signed(k1))
                                       + mul_q(coef[6 + j], $signed(k2))));
        end
        for (int j = 0; j < 2; j++) begin
            a3_next[j] = sigmoid(sat16(25'(coef[9 + j])
                                       + mul_q(coef[11 + j], a2_r[0])
                                       + mul_q(coef[13 + j], a2_r[1])
                                       + mul_q(coef[15 + j], a2_r[2])));
        end
    end

    logic [1:0] state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rom_addr <= 2'd0;
            k1 <= '0;
            k2 <= '0;
            t1 <= '0;
            t2 <= '0;
            for (int i = 0; i < 3; i++) a2_r[i] <= '0;
            for (int i = 0; i < 2; i++) a3_r[i] <= '0;
        end else begin
            case (state)
                IDLE: if (din) state <= FETCH;
                FETCH: begin
                    k1 <= fetch_k1;
                    k2 <= fetch_k2;
                    t1 <= rom_t1;
                    t2 <= rom_t2;
                    rom_addr <= rom_addr + 2'd1;
                    state <= L2;
                end
                L2: begin
                    for (int i = 0; i < 3; i++) a2_r[i] <= a2_next[i];
                    state <= L3;
                end
                default: begin
                    for (int i = 0; i < 2; i++) a3_r[i] <= a3_next[i];
                    state <= IDLE;
                end
            endcase
        end
    end

    assign a2_1 = a2_r[0];
    assign a2_2 = a2_r[1];
    assign a2_3 = a2_r[2];
    assign a3_1 = a3_r[0];
    assign a3_2 = a3_r[1];

endmodule

// File: tb/tb_nn_forward.sv
// Directed testbench for nn_forward: reset, coefficient init + forward pass,
// saturating update, load priority, sigmoid boundaries, mid-pass reset and
// ROM wrap with din held.

module tb_nn_forward;

    logic        clk = 1'b0;
    logic        reset, din, select_initial, update_coeff;
    logic [15:0] input_k_1, input_k_2;
    logic [15:0] d_b2_1, d_b2_2, d_b2_3;
    logic [15:0] d_w2_11, d_w2_12, d_w2_13, d_w2_21, d_w2_22, d_w2_23;
    logic [15:0] d_b3_1, d_b3_2;
    logic [15:0] d_w3_11, d_w3_12, d_w3_21, d_w3_22, d_w3_31, d_w3_32;
    logic [15:0] w3_11, w3_12, w3_21, w3_22, w3_31, w3_32;
    logic [15:0] a2_1, a2_2, a2_3, a3_1, a3_2;
    logic [15:0] k1, k2, t1, t2;
    logic        finish_updating;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nn_forward dut (
        .clk(clk), .reset(reset), .din(din),
        .select_initial(select_initial), .update_coeff(update_coeff),
        .input_k_1(input_k_1), .input_k_2(input_k_2),
        .cap_delta_b2_1(d_b2_1), .cap_delta_b2_2(d_b2_2), .cap_delta_b2_3(d_b2_3),
        .cap_delta_w2_11(d_w2_11), .cap_delta_w2_12(d_w2_12), .cap_delta_w2_13(d_w2_13),
        .cap_delta_w2_21(d_w2_21), .cap_delta_w2_22(d_w2_22), .cap_delta_w2_23(d_w2_23),
        .cap_delta_b3_1(d_b3_1), .cap_delta_b3_2(d_b3_2),
        .cap_delta_w3_11(d_w3_11), .cap_delta_w3_12(d_w3_12),
        .cap_delta_w3_21(d_w3_21), .cap_delta_w3_22(d_w3_22),
        .cap_delta_w3_31(d_w3_31), .cap_delta_w3_32(d_w3_32),
        .w3_11(w3_11), .w3_12(w3_12), .w3_21(w3_21),
        .w3_22(w3_22), .w3_31(w3_31), .w3_32(w3_32),
        .a2_1(a2_1), .a2_2(a2_2), .a2_3(a2_3),
        .a3_1(a3_1), .a3_2(a3_2),
        .k1(k1), .k2(k2), .t1(t1), .t2(t2),
        .finish_updating(finish_updating)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag,
                   $signed(observed), $signed(expected));
        end
    endtask

    task automatic check_bit(input string tag, input logic observed,
                             input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic zero_deltas();
        d_b2_1 = 0; d_b2_2 = 0; d_b2_3 = 0;
        d_w2_11 = 0; d_w2_12 = 0; d_w2_13 = 0;
        d_w2_21 = 0; d_w2_22 = 0; d_w2_23 = 0;
        d_b3_1 = 0; d_b3_2 = 0;
        d_w3_11 = 0; d_w3_12 = 0; d_w3_21 = 0;
        d_w3_22 = 0; d_w3_31 = 0; d_w3_32 = 0;
    endtask

    logic [15:0] exp_k1 [5] = '{16'd8192, 16'd1024, 16'd2048, 16'd0, 16'd8192};
    logic [15:0] exp_k2 [5] = '{16'd8192, 16'd2048, 16'd1024, 16'd0, 16'd8192};
    logic [15:0] exp_t1 [5] = '{16'd1024, 16'd0,    16'd1024, 16'd0, 16'd1024};
    logic [15:0] exp_t2 [5] = '{16'd0,    16'd1024, 16'd0, 16'd1024, 16'd0};

    initial begin
        reset = 1'b0; din = 1'b0; select_initial = 1'b0; update_coeff = 1'b0;
        input_k_1 = 16'd3333; input_k_2 = 16'd4444;
        zero_deltas();

        // Reset
        tick();
        reset = 1'b1;
        check("rst_w3_11", w3_11, 16'd0);
        check("rst_w3_32", w3_32, 16'd0);
        check("rst_a2_1", a2_1, 16'd0);
        check("rst_a3_2", a3_2, 16'd0);
        check("rst_k1", k1, 16'd0);
        check("rst_t2", t2, 16'd0);
        check_bit("rst_finish", finish_updating, 1'b0);

        // Coefficient init
        d_b2_1 = 16'hfc00; d_b2_2 = 16'hfc00; d_b2_3 = 16'hfc00;
        d_w2_11 = 16'd102; d_w2_21 = 16'd410;
        d_w2_12 = 16'd307; d_w2_22 = 16'd512;
        d_w2_13 = 16'd614; d_w2_23 = 16'd102;
        d_b3_1 = 16'hfc00; d_b3_2 = 16'hfc00;
        d_w3_11 = 16'd717; d_w3_21 = 16'd205; d_w3_31 = 16'd1331;
        d_w3_12 = 16'd205; d_w3_22 = 16'd512; d_w3_32 = 16'd1126;
        select_initial = 1'b1;
        tick();
        select_initial = 1'b0;
        check("init_w3_11", w3_11, 16'd717);
        check("init_w3_32", w3_32, 16'd1126);
        check_bit("init_no_pulse", finish_updating, 1'b0);

        // Forward pass on ROM entry 0
        din = 1'b1;
        tick();
        din = 1'b0;
        tick();
        check("p0_k1", k1, 16'd8192);
        check("p0_k2", k2, 16'd8192);
        check("p0_t1", t1, 16'd1024);
        check("p0_t2", t2, 16'd0);
        check("p0_a2_not_yet", a2_1, 16'd0);
        tick();
        check("p0_a2_1", a2_1, 16'd960);
        check("p0_a2_2", a2_2, 16'd1024);
        check("p0_a2_3", a2_3, 16'd1011);
        check("p0_a3_not_yet", a3_1, 16'd0);
        tick();
        check("p0_a3_1", a3_1, 16'd785);
        check("p0_a3_2", a3_2, 16'd709);
        tick();
        check("p0_a3_hold", a3_1, 16'd785);

        // Single update
        zero_deltas();
        d_w3_11 = 16'd102;
        update_coeff = 1'b1;
        tick();
        update_coeff = 1'b0;
        check("upd_w3_11", w3_11, 16'd819);
        check("upd_w3_12_hold", w3_12, 16'd205);
        check_bit("upd_pulse", finish_updating, 1'b1);
        tick();
        check_bit("upd_pulse_end", finish_updating, 1'b0);

        // Back-to-back updates
        zero_deltas();
        d_w3_12 = 16'd1;
        update_coeff = 1'b1;
        tick();
        check("b2b_w3_12_a", w3_12, 16'd206);
        check_bit("b2b_pulse_a", finish_updating, 1'b1);
        tick();
        update_coeff = 1'b0;
        check("b2b_w3_12_b", w3_12, 16'd207);
        check_bit("b2b_pulse_b", finish_updating, 1'b1);
        tick();
        check_bit("b2b_pulse_end", finish_updating, 1'b0);

        // Priority: load wins, no pulse
        zero_deltas();
        d_w3_11 = 16'd32000;
        select_initial = 1'b1;
        update_coeff = 1'b1;
        tick();
        select_initial = 1'b0;
        check("prio_w3_11", w3_11, 16'd32000);
        check("prio_w3_12", w3_12, 16'd0);
        check_bit("prio_no_pulse", finish_updating, 1'b0);
        d_w3_11 = 16'd2000;
        tick();
        update_coeff = 1'b0;
        check("sat_pos", w3_11, 16'h7fff);
        check_bit("sat_pulse", finish_updating, 1'b1);

        // Negative saturation
        d_w3_11 = 16'h8300;
        select_initial = 1'b1;
        tick();
        select_initial = 1'b0;
        d_w3_11 = 16'hf830;
        update_coeff = 1'b1;
        tick();
        update_coeff = 1'b0;
        check("sat_neg", w3_11, 16'h8000);

        // Sigmoid boundaries via biases (all weights zero), ROM entry 1
        zero_deltas();
        d_b2_1 = 16'he800;
        d_b2_3 = 16'd5120;
        d_b3_1 = 16'hfc00;
        d_b3_2 = 16'd2432;
        select_initial = 1'b1;
        tick();
        select_initial = 1'b0;
        zero_deltas();
        din = 1'b1;
        tick();
        din = 1'b0;
        tick();
        check("p1_k1", k1, 16'd1024);
        check("p1_k2", k2, 16'd2048);
        check("p1_t2", t2, 16'd1024);
        tick();
        check("sig_neg6", a2_1, 16'd0);
        check("sig_zero", a2_2, 16'd512);
        check("sig_pos5", a2_3, 16'd1024);
        tick();
        check("sig_neg1", a3_1, 16'd256);
        check("sig_2p375", a3_2, 16'd940);

        // Reset mid-pass, ROM entry 2
        tick();
        din = 1'b1;
        tick();
        din = 1'b0;
        tick();
        check("p2_k1", k1, 16'd2048);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_k1", k1, 16'd0);
        check("midrst_b2_w3", w3_11, 16'd0);
        tick();
        tick();
        check("midrst_a2", a2_2, 16'd0);
        check("midrst_a3", a3_1, 16'd0);

        // din held: passes restart every 4 cycles, ROM wraps
        din = 1'b1;
        tick();
        for (int p = 0; p < 5; p++) begin
            tick();
            check($sformatf("wrap%0d_k1", p), k1, exp_k1[p]);
            check($sformatf("wrap%0d_k2", p), k2, exp_k2[p]);
            check($sformatf("wrap%0d_t1", p), t1, exp_t1[p]);
            check($sformatf("wrap%0d_t2", p), t2, exp_t2[p]);
            tick();
            tick();
            tick();
        end
        din = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
